// File: rtl/irq_request_latch.sv
// Eight-source interrupt request latch: edge capture into a sticky pending vector,
// fixed-priority grant presentation held until acknowledged, and a sticky overrun flag.
module irq_request_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       irq_ack,
    output logic [7:0] pending,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic       overrun
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0] state_reg, state_next;
    logic [7:0] req_d_reg;
    logic [7:0] pending_reg, pending_next;
    logic       irq_valid_reg, irq_valid_next;
    logic [2:0] irq_id_reg, irq_id_next;
    logic       overrun_reg, overrun_next;

    logic [7:0] capture;
    logic [7:0] clear;
    logic [7:0] overrun_hit;
    logic [7:0] elig;
    logic       ack_clear;
    logic       win_found;
    logic [2:0] win_idx;

    assign ack_clear = (state_reg == PRESENT) && irq_ack;
    assign elig      = pending_reg & ~mask;

    // A set from a new edge always beats the acknowledge clear on the same bit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign capture[gi]      = en & req[gi] & ~req_d_reg[gi];
            assign clear[gi]        = ack_clear && (irq_id_reg == 3'(gi));
            assign pending_next[gi] = capture[gi] | (pending_reg[gi] & ~clear[gi]);
            assign overrun_hit[gi]  = capture[gi] & pending_reg[gi] & ~clear[gi];
        end
    endgenerate

    assign overrun_next = overrun_reg | (|overrun_hit);

    // Ascending scan so the highest eligible index is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (elig[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        irq_valid_next = irq_valid_reg;
        irq_id_next    = irq_id_reg;
        case (state_reg)
            IDLE: begin
                irq_valid_next = 1'b0;
                if (win_found) begin
                    state_next     = PRESENT;
                    irq_valid_next = 1'b1;
                    irq_id_next    = win_idx;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    state_next     = IDLE;
                    irq_valid_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                irq_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_d_reg     <= 8'h00;
            pending_reg   <= 8'h00;
            irq_valid_reg <= 1'b0;
            irq_id_reg    <= 3'b000;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_d_reg     <= req;
            pending_reg   <= pending_next;
            irq_valid_reg <= irq_valid_next;
            irq_id_reg    <= irq_id_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign pending   = pending_reg;
    assign irq_valid = irq_valid_reg;
    assign irq_id    = irq_id_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_irq_request_latch.sv
// Bench for irq_request_latch: directed vector table followed by randomized
// traffic checked against a cycle-level behavioural model.
module tb_irq_request_latch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       irq_ack = 1'b0;
    logic [7:0] pending;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    bit [7:0] m_pend;
    bit [7:0] m_reqd;
    bit       m_valid;
    int       m_id;
    bit       m_ovr;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic [7:0] p;
        logic       v;
        logic [2:0] id;
        logic       o;
    } vec_t;

    localparam int NVEC = 33;
    vec_t tbl [NVEC];

    irq_request_latch dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .mask     (mask),
        .irq_ack  (irq_ack),
        .pending  (pending),
        .irq_valid(irq_valid),
        .irq_id   (irq_id),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(logic r, logic e, logic [7:0] rq, logic [7:0] mk, logic a,
                                 logic [7:0] p, logic v, logic [2:0] id, logic o);
        vec_t x;
        x.rst = r; x.en = e; x.req = rq; x.mask = mk; x.ack = a;
        x.p = p; x.v = v; x.id = id; x.o = o;
        return x;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Applies one clock cycle of inputs and advances the model by the same edge.
    task automatic step(input logic r, input logic e, input logic [7:0] rq,
                        input logic [7:0] mk, input logic a);
        bit [7:0] rise;
        bit [7:0] np;
        int hi;
        rst = r; en = e; req = rq; mask = mk; irq_ack = a;
        if (r) begin
            m_pend = 0; m_reqd = 0; m_valid = 0; m_id = 0; m_ovr = 0;
        end else begin
            rise = e ? (rq & ~m_reqd) : 8'h00;
            hi = -1;
            for (int i = 0; i < 8; i++)
                if (m_pend[i] && !mk[i]) hi = i;
            np = m_pend;
            for (int i = 0; i < 8; i++) begin
                bit cleared;
                cleared = m_valid && a && (m_id == i);
                if (rise[i]) begin
                    if (m_pend[i] && !cleared) m_ovr = 1;
                    np[i] = 1;
                end else if (cleared) begin
                    np[i] = 0;
                end
            end
            if (m_valid) begin
                if (a) m_valid = 0;
            end else if (hi >= 0) begin
                m_valid = 1;
                m_id = hi;
            end
            m_pend = np;
            m_reqd = rq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input logic [7:0] p, input logic v,
                           input logic [2:0] id, input logic o, input logic chk_id);
        check({tag, ".pending"}, int'(pending), int'(p));
        check({tag, ".irq_valid"}, int'(irq_valid), int'(v));
        check({tag, ".overrun"}, int'(overrun), int'(o));
        if (chk_id) check({tag, ".irq_id"}, int'(irq_id), int'(id));
        $display("cyc %s rst=%0b en=%0b req=%02h mask=%02h ack=%0b -> pend=%02h v=%0b id=%0d ovr=%0b",
                 tag, rst, en, req, mask, irq_ack, pending, irq_valid, irq_id, overrun);
    endtask

    initial begin
        // Reset and single request
        tbl[0]  = mkv(1, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mkv(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        tbl[2]  = mkv(0, 1, 8'h10, 8'h00, 0, 8'h10, 0, 0, 0);
        tbl[3]  = mkv(0, 1, 8'h10, 8'h00, 0, 8'h10, 1, 4, 0);
        tbl[4]  = mkv(0, 1, 8'h10, 8'h00, 0, 8'h10, 1, 4, 0);
        tbl[5]  = mkv(0, 1, 8'h10, 8'h00, 1, 8'h00, 0, 0, 0);
        tbl[6]  = mkv(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        // Priority
        tbl[7]  = mkv(0, 1, 8'h81, 8'h00, 0, 8'h81, 0, 0, 0);
        tbl[8]  = mkv(0, 1, 8'h81, 8'h00, 0, 8'h81, 1, 7, 0);
        tbl[9]  = mkv(0, 1, 8'h81, 8'h00, 1, 8'h01, 0, 0, 0);
        tbl[10] = mkv(0, 1, 8'h81, 8'h00, 0, 8'h01, 1, 0, 0);
        tbl[11] = mkv(0, 1, 8'h81, 8'h00, 1, 8'h00, 0, 0, 0);
        tbl[12] = mkv(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        // Mask and hold
        tbl[13] = mkv(0, 1, 8'h40, 8'h40, 0, 8'h40, 0, 0, 0);
        tbl[14] = mkv(0, 1, 8'h40, 8'h40, 0, 8'h40, 0, 0, 0);
        tbl[15] = mkv(0, 1, 8'h40, 8'h00, 0, 8'h40, 1, 6, 0);
        tbl[16] = mkv(0, 1, 8'h40, 8'h40, 0, 8'h40, 1, 6, 0);
        tbl[17] = mkv(0, 1, 8'h40, 8'h40, 1, 8'h00, 0, 0, 0);
        tbl[18] = mkv(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        // en gating, set-beats-clear, overrun
        tbl[19] = mkv(0, 0, 8'h04, 8'h00, 0, 8'h00, 0, 0, 0);
        tbl[20] = mkv(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        tbl[21] = mkv(0, 1, 8'h08, 8'h00, 0, 8'h08, 0, 0, 0);
        tbl[22] = mkv(0, 1, 8'h00, 8'h00, 0, 8'h08, 1, 3, 0);
        tbl[23] = mkv(0, 1, 8'h08, 8'h00, 1, 8'h08, 0, 0, 0);
        tbl[24] = mkv(0, 1, 8'h00, 8'h00, 0, 8'h08, 1, 3, 0);
        tbl[25] = mkv(0, 1, 8'h08, 8'h00, 0, 8'h08, 1, 3, 1);
        tbl[26] = mkv(0, 1, 8'h00, 8'h00, 1, 8'h00, 0, 0, 1);
        // Reset while presenting, held request through release
        tbl[27] = mkv(0, 1, 8'hFF, 8'h00, 0, 8'hFF, 0, 0, 1);
        tbl[28] = mkv(0, 1, 8'hFF, 8'h00, 0, 8'hFF, 1, 7, 1);
        tbl[29] = mkv(1, 1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0);
        tbl[30] = mkv(0, 1, 8'h01, 8'h00, 0, 8'h01, 0, 0, 0);
        tbl[31] = mkv(0, 1, 8'h01, 8'h00, 0, 8'h01, 1, 0, 0);
        tbl[32] = mkv(0, 1, 8'h01, 8'h00, 1, 8'h00, 0, 0, 0);

        for (int k = 0; k < NVEC; k++) begin
            step(tbl[k].rst, tbl[k].en, tbl[k].req, tbl[k].mask, tbl[k].ack);
            compare($sformatf("vec%0d", k), tbl[k].p, tbl[k].v, tbl[k].id, tbl[k].o,
                    tbl[k].v | tbl[k].rst);
        end

        // Randomized traffic against the model; model state is already in sync.
        for (int k = 0; k < 400; k++) begin
            logic r, e, a;
            logic [7:0] rq, mk;
            r  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 3) != 0);
            rq = 8'($urandom);
            mk = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            a  = ($urandom_range(0, 2) == 0);
            step(r, e, rq, mk, a);
            compare($sformatf("rnd%0d", k), m_pend, m_valid, 3'(m_id), m_ovr, m_valid | r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_request_latch.md
IRQ_REQUEST_LATCH -- requirements
Module: irq_request_latch

Interface
REQ-001 The block SHALL have no parameters: request width is fixed at 8, grant index width at 3.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 en  input  1  capture enable; 1 = new request edges are latched, 0 = new edges are ignored.
REQ-005 req  input  8  raw request lines; bit i = source i.
REQ-006 mask  input  8  per-source mask; 1 = source not eligible for grant, pending bit still kept.
REQ-007 irq_ack  input  1  consumer acknowledge of the presented grant.
REQ-008 pending  output  8  registered sticky pending vector.
REQ-009 irq_valid  output  1  registered; 1 = irq_id holds a valid grant.
REQ-010 irq_id  output  3  registered index of the granted source.
REQ-011 overrun  output  1  registered sticky flag: a request edge arrived for an already-pending source.

Function
REQ-012 Edge detect: req_d SHALL be a register loaded with req every cycle, regardless of en. edge[i] = req[i] & ~req_d[i].
REQ-013 Capture: when en=1 and edge[i]=1, pending[i] SHALL be 1 after that same rising edge. When en=0, edges SHALL be discarded and pending SHALL hold.
REQ-014 Eligible set: elig = pending & ~mask. Priority SHALL be fixed, with bit 7 highest and bit 0 lowest. irq_id SHALL equal the index of the highest set bit of elig.
REQ-015 The FSM SHALL have two states, IDLE and PRESENT.
REQ-016 IDLE: if elig != 0, the FSM SHALL load irq_id with the winning index, set irq_valid=1 and go to PRESENT. Otherwise it SHALL stay in IDLE with irq_valid=0.
REQ-017 PRESENT: irq_valid=1 and irq_id SHALL be held stable until irq_ack=1 is sampled. Changes to mask, pending or req SHALL NOT withdraw or alter the grant.
REQ-018 PRESENT with irq_ack=1: clear pending[irq_id], set irq_valid=0, go to IDLE. Minimum one IDLE cycle between consecutive grants.
REQ-019 irq_ack sampled in IDLE SHALL be ignored.
REQ-020 en SHALL gate capture only. FSM, grant and ack SHALL operate regardless of en.
REQ-021 Latency: a req edge sampled at rising edge k SHALL give pending at k and irq_valid=1 after k+1 (2 cycles), if IDLE and unmasked.
REQ-022 Simultaneous ack-clear and new edge on the same bit (en=1): set SHALL win, pending stays 1, overrun unchanged.
REQ-023 With en=1, an edge on bit i while pending[i]=1 and bit i is not being cleared that cycle SHALL set overrun=1. overrun SHALL clear only on rst.
REQ-024 Edges on multiple bits in the same cycle SHALL all be latched.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL load pending=8'h00, req_d=8'h00, state=IDLE, irq_valid=0, irq_id=3'b000, overrun=0. rst SHALL override all other inputs.
REQ-026 Because req_d resets to 0, a req bit held high on the first cycle after rst release SHALL count as an edge.
REQ-027 rst asserted in PRESENT SHALL drop the grant with no ack required, and pending SHALL be lost.

Verification
REQ-028 Single request: en=1, mask=0, req 8'h00->8'h10 at edge k -> pending=8'h10 at k, irq_valid=1 and irq_id=4 after k+1. irq_ack at k+3 -> pending=0, irq_valid=0 after k+3.
REQ-029 Priority: req edges 8'h81 in one cycle -> first grant irq_id=7. After ack, one IDLE cycle, then irq_id=0. After second ack, pending=0.
REQ-030 Mask and hold: pending=8'h40 with mask=8'h40 -> irq_valid stays 0. mask->0 -> grant id 6. Setting mask=8'h40 during PRESENT -> irq_id remains 6 until ack.
REQ-031 en gating and overrun: en=0, req edge on bit 2 -> pending unchanged. en=1, edge on bit 3 twice before ack -> overrun=1. Same-cycle ack of id 3 plus new edge on bit 3 -> pending[3]=1, overrun not set by that event.
REQ-032 Reset: rst=1 in PRESENT with pending=8'hFF -> all outputs zero next cycle. req held 8'h01 through rst release -> pending=8'h01 after the first post-reset edge.
